intr_sequencer: RTL

Interrupt controller and entry sequencer for the 8-bit five-stage pipeline. It latches edge-triggered requests from up to eight sources, masks and prioritises them, and drains the pipeline by stalling fetch. It then issues a single one-cycle entry pulse with a per-source vector address to the PC unit and IF/ID flush logic. It blocks further entries until the return-from-interrupt reaches WB, so interrupts do not nest.

---
 rtl/intr_sequencer_if.sv | 28 ++
 rtl/intr_sequencer.sv | 129 ++++++++++++
 2 files changed

// File: rtl/intr_sequencer_if.sv
// Bundle of request, configuration and pipeline-control signals for intr_sequencer.
// The master side (pipeline/CPU) drives requests and config; the slave side is the sequencer.
interface intr_sequencer_if #(
    parameter int unsigned NUM_SRC = 4
);
    logic [NUM_SRC-1:0] irq_in;
    logic               cfg_we;
    logic               cfg_addr;
    logic [7:0]         cfg_wdata;
    logic [7:0]         cfg_rdata;
    logic               pipe_hazard;
    logic               rti_wb;
    logic               stall_fetch;
    logic               intr_pulse;
    logic [7:0]         vector_addr;
    logic [2:0]         active_src;
    logic               in_service;

    modport master (
        output irq_in, cfg_we, cfg_addr, cfg_wdata, pipe_hazard, rti_wb,
        input  cfg_rdata, stall_fetch, intr_pulse, vector_addr, active_src, in_service
    );

    modport slave (
        input  irq_in, cfg_we, cfg_addr, cfg_wdata, pipe_hazard, rti_wb,
        output cfg_rdata, stall_fetch, intr_pulse, vector_addr, active_src, in_service
    );
endinterface

// File: rtl/intr_sequencer.sv
// Non-nesting interrupt controller: latches request edges, picks the lowest eligible
// source, drains the pipeline, then fires a one-cycle entry pulse with the vector address.
module intr_sequencer #(
    parameter int unsigned NUM_SRC      = 4,
    parameter logic [7:0]  VEC_BASE     = 8'd1,
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter logic [7:0]  MASK_RST     = 8'hFF
) (
    input  logic              clk,
    input  logic              rst,
    intr_sequencer_if.slave   bus
);
    localparam int unsigned NW = NUM_SRC;
    localparam logic [2:0]  CNT_LOAD = 3'(DRAIN_CYCLES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRAIN   = 2'd1,
        ENTER   = 2'd2,
        SERVICE = 2'd3
    } state_t;

    state_t          state;
    logic [2:0]      cnt;
    logic [NW-1:0]   irq_q;
    logic [NW-1:0]   pending;
    logic [NW-1:0]   mask;
    logic [NW-1:0]   eligible;
    logic [NW-1:0]   rise;
    logic [NW-1:0]   clr;
    logic [2:0]      win_idx;
    logic            win_found;
    logic            mask_we;
    logic            clr_we;
    logic [2:0]      active_src;

    assign mask_we  = bus.cfg_we && (bus.cfg_addr == 1'b0);
    assign clr_we   = bus.cfg_we && (bus.cfg_addr == 1'b1);
    assign rise     = bus.irq_in & ~irq_q;
    assign eligible = pending & mask;

    // Software clear plus auto-clear of the source being entered; a same-cycle edge still sets.
    always_comb begin
        clr = clr_we ? bus.cfg_wdata[NW-1:0] : '0;
        if (state == ENTER) begin
            clr = clr | (NW'(1) << active_src);
        end
    end

    // Lowest index wins: scan downward so the last hit is the smallest index.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 3'd0;
        for (int i = NW - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_found = 1'b1;
                win_idx   = 3'(i);
            end
        end
    end

    assign bus.cfg_rdata  = bus.cfg_addr ? 8'(pending) : 8'(mask);
    assign bus.active_src = active_src;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_q   <= '0;
            pending <= '0;
            mask    <= MASK_RST[NW-1:0];
        end else begin
            irq_q   <= bus.irq_in;
            pending <= (pending & ~clr) | rise;
            if (mask_we) begin
                mask <= bus.cfg_wdata[NW-1:0];
            end
        end
    end

    // Sequencer with outputs registered alongside the state they decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= 3'd0;
            active_src      <= 3'd0;
            bus.vector_addr <= VEC_BASE;
            bus.stall_fetch <= 1'b0;
            bus.intr_pulse  <= 1'b0;
            bus.in_service  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        state           <= DRAIN;
                        active_src      <= win_idx;
                        bus.vector_addr <= VEC_BASE + 8'(win_idx);
                        cnt             <= CNT_LOAD;
                        bus.stall_fetch <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (bus.pipe_hazard) begin
                        cnt <= CNT_LOAD;
                    end else begin
                        cnt <= cnt - 3'd1;
                        if (cnt == 3'd1) begin
                            state          <= ENTER;
                            bus.intr_pulse <= 1'b1;
                        end
                    end
                end
                ENTER: begin
                    state           <= SERVICE;
                    bus.intr_pulse  <= 1'b0;
                    bus.stall_fetch <= 1'b0;
                    bus.in_service  <= 1'b1;
                end
                SERVICE: begin
                    if (bus.rti_wb) begin
                        state          <= IDLE;
                        bus.in_service <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
